// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU wrapper constants, result type and helpers
package fpu_pkg;

    localparam int FDIV_LAT  = 4;
    localparam int FPU_TAG_W = 6;

    typedef struct packed {
        logic [31:0]          y;
        logic                 ovf;
        logic [FPU_TAG_W-1:0] tag;
    } fpu_result_t;

    // Number of set bits; used to count in-flight ops in the valid pipe
    function automatic int popcount(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// rtl/fpu_result_fifo.sv - synchronous result FIFO with registered head and occupancy count
module fpu_result_fifo
    import fpu_pkg::*;
#(
    parameter int W     = $bits(fpu_result_t),
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   cnt;
    logic          do_pop;

    // A pop on an empty FIFO is ignored so callers may pass a raw ready
    assign do_pop = pop && (cnt != '0);

    // Pointers wrap naturally because DEPTH is a power of two; clr beats push/pop
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible once cnt covers it
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head_valid = (cnt != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;
    assign count      = cnt;

    overflow_chk: assert property (@(posedge clk) disable iff (rst || clr)
        !(push && !do_pop && (cnt == (AW+1)'(DEPTH))));

endmodule

// File: rtl/fdiv_issue_ctrl.sv
// rtl/fdiv_issue_ctrl.sv - credit-gated issue and writeback wrapper around the fdiv pipeline
module fdiv_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int LAT   = FDIV_LAT,
    parameter int TAG_W = FPU_TAG_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x1,
    input  logic [31:0]      in_x2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      div_x1,
    output logic [31:0]      div_x2,
    input  logic [31:0]      div_y,
    input  logic             div_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int RW = 33 + TAG_W;

    logic [LAT-1:0]         pipe_v;
    logic [TAG_W-1:0]       pipe_tag [LAT];
    logic [$clog2(DEPTH):0] cnt;
    logic [RW-1:0]          head_data;
    logic                   accept;
    logic                   push;
    logic                   pop;
    int                     inflight;

    // fdiv has no stall input, so operands always flow straight through
    assign div_x1 = in_x1;
    assign div_x2 = in_x2;

    // Every op in the pipe already owns a FIFO slot; a same-cycle pop is not counted
    assign inflight = popcount(32'(pipe_v));
    assign in_ready = !rst && !flush && ((inflight + int'(cnt)) < DEPTH);
    assign accept   = in_valid && in_ready;

    assign push = pipe_v[LAT-1] && !flush;
    assign pop  = out_valid && out_ready && !flush;

    // Valid bits track which fdiv pipeline slots hold real ops
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pipe_v <= '0;
        end else begin
            pipe_v <= {pipe_v[LAT-2:0], accept};
        end
    end

    // Tags ride alongside; their value only matters where the valid bit is set
    always_ff @(posedge clk) begin
        pipe_tag[0] <= in_tag;
        for (int k = 1; k < LAT; k++) begin
            pipe_tag[k] <= pipe_tag[k-1];
        end
    end

    fpu_result_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr        (flush),
        .push       (push),
        .push_data  ({div_y, div_ovf, pipe_tag[LAT-1]}),
        .pop        (pop),
        .head_valid (out_valid),
        .head_data  (head_data),
        .count      (cnt)
    );

    assign {out_y, out_ovf, out_tag} = head_data;
    assign busy = (pipe_v != '0) || (cnt != '0);

endmodule
